piso_shift_reader: RTL and testbench

- Reads a w-bit parallel word from the register datapath and emits it one bit per accepted transfer on a valid/ready serial stream.
- It is the read/unload end of the parallel register interface. It hands ALU results or operands to bit-serial consumers such as debug taps, serial links and the bit-serial checker.
- Internally it combines a loadable shift register, a bit counter and a two-state FSM.

---
 rtl/alu_pkg.sv | 14 +
 rtl/piso_bit_counter.sv | 40 ++++
 rtl/piso_shift_reader.sv | 90 +++++++++
 tb/tb_piso_shift_reader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the register-datapath serial readers.
package alu_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Counter width for indexing w bits; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit index counter for the serialiser: clears on load/flush/last, never wraps.
module piso_bit_counter
    import alu_pkg::*;
#(
    parameter int w = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [cnt_width(w)-1:0] count,
    output logic                    at_last
);

    localparam int CW = cnt_width(w);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_last = (count_q == CW'(w - 1));

endmodule

// File: rtl/piso_shift_reader.sv
// Parallel-in, serial-out reader: loads a w-bit word and emits it one bit per
// accepted valid/ready transfer, LSB- or MSB-first.
module piso_shift_reader
    import alu_pkg::*;
#(
    parameter int w         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [w-1:0] in_data,
    input  logic         flush,
    output logic         bit_out,
    output logic         bit_valid,
    input  logic         bit_ready,
    output logic         bit_last,
    output logic         busy
);

    localparam int CW = cnt_width(w);

    piso_state_t   state_q;
    piso_state_t   state_d;
    logic [w-1:0]  shift_q;
    logic [w-1:0]  shift_d;
    logic          load;
    logic          adv;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          at_last;
    logic [CW-1:0] cnt_count;

    // flush outranks both the bit handshake and a load in the same cycle
    assign load = (state_q == IDLE) & in_valid & ~flush;
    assign adv  = (state_q == SHIFT) & bit_ready & ~flush;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        if (flush) begin
            state_d = IDLE;
            shift_d = '0;
        end else if (load) begin
            state_d = SHIFT;
            shift_d = in_data;
        end else if (adv) begin
            shift_d = MSB_FIRST ? {shift_q[w-2:0], 1'b0} : {1'b0, shift_q[w-1:1]};
            if (at_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    assign cnt_clr = flush | load | (adv & at_last);
    assign cnt_inc = adv & ~at_last;

    piso_bit_counter #(
        .w(w)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (cnt_count),
        .at_last(at_last)
    );

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign bit_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign bit_out   = MSB_FIRST ? shift_q[w-1] : shift_q[0];
    assign bit_last  = at_last & bit_valid;

    a_count_in_range: assert property (
        @(posedge clk) disable iff (rst) cnt_count <= CW'(w - 1)
    );

endmodule

// File: tb/tb_piso_shift_reader.sv
// Directed bench: one LSB-first and one MSB-first instance share all stimulus.
module tb_piso_shift_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       flush = 1'b0;
    logic       bit_ready = 1'b0;

    logic in_ready_l, bit_out_l, bit_valid_l, bit_last_l, busy_l;
    logic in_ready_m, bit_out_m, bit_valid_m, bit_last_m, busy_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_shift_reader #(.w(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .flush(flush), .bit_out(bit_out_l),
        .bit_valid(bit_valid_l), .bit_ready(bit_ready), .bit_last(bit_last_l),
        .busy(busy_l)
    );

    piso_shift_reader #(.w(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .flush(flush), .bit_out(bit_out_m),
        .bit_valid(bit_valid_m), .bit_ready(bit_ready), .bit_last(bit_last_m),
        .busy(busy_m)
    );

    // seq_* bit [0] is the first bit on the wire
    typedef struct {
        logic [7:0] word;
        logic [0:7] seq_l;
        logic [0:7] seq_m;
        int         stall_at;
        int         stall_len;
        bit         poke_valid;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check({tag, " in_ready_l"}, 32'(in_ready_l), 32'(exp_ready));
        check({tag, " in_ready_m"}, 32'(in_ready_m), 32'(exp_ready));
        check({tag, " bit_valid"}, {30'd0, bit_valid_l, bit_valid_m}, 32'd0);
        check({tag, " busy"}, {30'd0, busy_l, busy_m}, 32'd0);
        check({tag, " bit_last"}, {30'd0, bit_last_l, bit_last_m}, 32'd0);
        check({tag, " bit_out"}, {30'd0, bit_out_l, bit_out_m}, 32'd0);
    endtask

    task automatic send_word(input vec_t v, input string tag);
        int cycles;
        @(negedge clk);
        check({tag, " ready before load"}, {30'd0, in_ready_l, in_ready_m}, 32'd3);
        in_valid  = 1'b1;
        in_data   = v.word;
        bit_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~v.word;
        cycles   = 1;
        check({tag, " busy after load"}, {29'd0, busy_l, busy_m, in_ready_l}, 32'd6);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s lsb bit%0d", tag, i), 32'(bit_out_l), 32'(v.seq_l[i]));
            check($sformatf("%s msb bit%0d", tag, i), 32'(bit_out_m), 32'(v.seq_m[i]));
            check($sformatf("%s last bit%0d", tag, i), {30'd0, bit_last_l, bit_last_m},
                  (i == 7) ? 32'd3 : 32'd0);
            check($sformatf("%s valid bit%0d", tag, i), {30'd0, bit_valid_l, bit_valid_m}, 32'd3);
            if (i == v.stall_at) begin
                bit_ready = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    @(negedge clk);
                    cycles++;
                    check($sformatf("%s stall%0d lsb", tag, s), 32'(bit_out_l), 32'(v.seq_l[i]));
                    check($sformatf("%s stall%0d msb", tag, s), 32'(bit_out_m), 32'(v.seq_m[i]));
                    check($sformatf("%s stall%0d last", tag, s), 32'(bit_last_l), 32'(i == 7));
                end
                bit_ready = 1'b1;
            end
            in_valid = v.poke_valid & i[0];
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        check({tag, " done ready"}, {30'd0, in_ready_l, in_ready_m}, 32'd3);
        check({tag, " done valid"}, {30'd0, bit_valid_l, bit_valid_m}, 32'd0);
        check({tag, " cycles"}, 32'(cycles), 32'(9 + v.stall_len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, -1, 0, 1'b0};
        vecs[1] = '{8'h01, 8'b10000000, 8'b00000001, -1, 0, 1'b0};
        vecs[2] = '{8'hF0, 8'b00001111, 8'b11110000, 1, 3, 1'b0};
        vecs[3] = '{8'h0F, 8'b11110000, 8'b00001111, -1, 0, 1'b1};
        vecs[4] = '{8'h3C, 8'b00111100, 8'b00111100, 6, 2, 1'b1};

        #1;
        check_idle("reset", 1'b0);
        repeat (2) @(negedge clk);
        check_idle("in reset", 1'b0);
        rst = 1'b0;
        #1;
        check_idle("post reset", 1'b1);

        foreach (vecs[k]) send_word(vecs[k], $sformatf("vec%0d", k));

        // Flush on bit 4 of 3C while a load of FF is attempted
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        bit_ready = 1'b1;
        @(negedge clk);
        in_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flush pre lsb bit%0d", i), 32'(bit_out_l), 32'(vecs[4].seq_l[i]));
            in_valid = 1'b1;
            @(negedge clk);
        end
        check("flush bit3 valid", 32'(bit_valid_l), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle("after flush", 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("flush no load", 1'b1);
        send_word(vecs[3], "post flush 0F");

        // Flush in IDLE blocks a load
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_idle("idle flush", 1'b1);

        // Asynchronous reset during bit 3
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre rst bit3", {29'd0, bit_out_l, bit_out_m, bit_valid_l}, 32'd7);
        #1 rst = 1'b1;
        #1;
        check_idle("async rst", 1'b0);
        @(negedge clk);
        check_idle("rst held", 1'b0);
        rst = 1'b0;
        #1;
        check_idle("rst release", 1'b1);
        send_word(vecs[0], "after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
